bytes_seq_ctrl: RTL and testbench

- Hardware sequence-combinator engine. Runs a small stored program of byte-class "take-while-m-n" steps over a streaming byte input.
- Forwards each matched byte, tagged with the step index that matched it.
- Reports success or failure, the failing step, and the number of bytes consumed.
- Unconsumed bytes stay in the input stream as the remainder for the downstream parser.

---
 rtl/bytes_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_bytes_seq_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bytes_seq_ctrl.sv
// bytes_seq_ctrl: runs a stored program of byte-class take-while-m-n steps over a byte stream.
module bytes_seq_ctrl #(
  parameter int MAX_STEPS = 8,
  parameter int STEP_AW   = $clog2(MAX_STEPS),
  parameter int CNT_W     = 8,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [STEP_AW-1:0]     cfg_addr,
  input  logic [11+2*CNT_W-1:0]  cfg_data,
  input  logic                   start,
  input  logic [STEP_AW:0]       num_steps,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic [STEP_AW-1:0]     out_step,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   ok,
  output logic [STEP_AW-1:0]     err_step,
  output logic [LEN_W-1:0]       consumed
);
  localparam int WW = 11 + 2*CNT_W;
  typedef enum logic [1:0] {IDLE, FETCH, MATCH, FINISH} state_t;
  state_t state_q, state_d;
  logic [STEP_AW-1:0] step_q, step_d, err_q, err_d;
  logic [STEP_AW:0]   nsteps_q, nsteps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, mn, mx;
  logic [LEN_W-1:0]   cons_q, cons_d;
  logic               ok_q, ok_d, eoi_q, eoi_d;
  logic [WW-1:0]      prog [MAX_STEPS];
  logic [2:0]         cls;
  logic [7:0]         lit;
  logic               hit, accept, step_end, last_step;
  function automatic logic class_hit(input logic [2:0] c, input logic [7:0] b, input logic [7:0] l);
    logic dg, al, hx, sp;
    logic [7:0] m;
    dg = b >= 8'h30 && b <= 8'h39;
    al = (b >= 8'h41 && b <= 8'h5a) || (b >= 8'h61 && b <= 8'h7a);
    hx = dg || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
    sp = b == 8'h20 || b == 8'h09 || b == 8'h0a || b == 8'h0d;
    m = {1'b0, b == l, 1'b1, hx, sp, dg | al, al, dg};
    return m[c];
  endfunction
  // The program only changes while idle, so the active step word is read straight from the RAM.
  always_ff @(posedge clk) if (cfg_we && state_q == IDLE) prog[cfg_addr] <= cfg_data;
  assign {cls, lit, mn, mx} = prog[step_q];
  assign hit       = class_hit(cls, in_data, lit);
  assign accept    = state_q == MATCH && !eoi_q && in_valid && hit && cnt_q < mx && out_ready;
  assign step_end  = state_q == MATCH && (eoi_q || cnt_q == mx || (in_valid && !hit));
  assign last_step = ({1'b0, step_q} + (STEP_AW+1)'(1)) == nsteps_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      err_q    <= '0;
      nsteps_q <= '0;
      cnt_q    <= '0;
      cons_q   <= '0;
      ok_q     <= 1'b0;
      eoi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      err_q    <= err_d;
      nsteps_q <= nsteps_d;
      cnt_q    <= cnt_d;
      cons_q   <= cons_d;
      ok_q     <= ok_d;
      eoi_q    <= eoi_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    err_d    = err_q;
    nsteps_d = nsteps_q;
    cnt_d    = cnt_q;
    cons_d   = cons_q;
    ok_d     = ok_q;
    eoi_d    = eoi_q;
    case (state_q)
      IDLE: if (start) begin
        nsteps_d = num_steps;
        step_d   = '0;
        cons_d   = '0;
        err_d    = '0;
        eoi_d    = 1'b0;
        ok_d     = num_steps == '0;
        state_d  = num_steps == '0 ? FINISH : FETCH;
      end
      FETCH: begin
        cnt_d   = '0;
        state_d = mx < mn ? FINISH : MATCH;
        err_d   = mx < mn ? step_q : err_q;
      end
      MATCH: if (accept) begin
        cnt_d  = cnt_q + CNT_W'(1);
        cons_d = &cons_q ? cons_q : cons_q + LEN_W'(1);
        eoi_d  = in_last;
      end else if (step_end) begin
        state_d = cnt_q < mn || last_step ? FINISH : FETCH;
        ok_d    = cnt_q >= mn && last_step;
        err_d   = cnt_q < mn ? step_q : err_q;
        step_d  = cnt_q >= mn && !last_step ? step_q + STEP_AW'(1) : step_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = accept;
  assign out_valid = accept;
  assign out_data  = in_data;
  assign out_step  = step_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == FINISH;
  assign ok        = ok_q;
  assign err_step  = err_q;
  assign consumed  = cons_q;
endmodule

// File: tb/tb_bytes_seq_ctrl.sv
// tb_bytes_seq_ctrl: directed runs with a queue scoreboard checking forwarded bytes and run results.
module tb_bytes_seq_ctrl;
  logic        clk = 0, rst_n = 0, cfg_we = 0, start = 0;
  logic [2:0]  cfg_addr = 0;
  logic [26:0] cfg_data = 0;
  logic [3:0]  num_steps = 0;
  logic        in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0]  in_data = 0;
  logic        in_ready, out_valid, busy, done, ok;
  logic [7:0]  out_data;
  logic [2:0]  out_step, err_step;
  logic [15:0] consumed;
  int tests = 0, fails = 0;
  logic [10:0] exp_q[$];

  bytes_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_steps(num_steps), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_step(out_step), .out_ready(out_ready), .busy(busy), .done(done), .ok(ok),
    .err_step(err_step), .consumed(consumed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (out_valid) begin
    logic [10:0] e;
    chk("in_ready_with_out_valid", int'(in_ready), 1);
    if (exp_q.size() == 0) chk("unexpected_out_byte", int'(out_data), -1);
    else begin
      e = exp_q.pop_front();
      chk("out_data", int'(out_data), int'(e[7:0]));
      chk("out_step", int'(out_step), int'(e[10:8]));
    end
  end

  task automatic wr(input int a, input int c, input int l, input int mn, input int mx);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = 3'(a); cfg_data = {3'(c), 8'(l), 8'(mn), 8'(mx)};
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic push(input string s, input int st);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({3'(st), 8'(s[i])});
  endtask

  task automatic run(input string s, input int last_pos, input int ns, input int st_lo, input int st_hi,
                     input int rst_at, input int exp_done, input int exp_ok, input int exp_err, input int exp_cons);
    int idx = 0, dcyc = -1;
    @(posedge clk); #1;
    start = 1; num_steps = 4'(ns);
    for (int it = 0; it < 60; it++) begin
      if (it > 0) start = 0;
      in_valid  = idx < s.len();
      in_data   = idx < s.len() ? 8'(s[idx]) : 8'h00;
      in_last   = idx == last_pos;
      out_ready = !(it >= st_lo && it <= st_hi);
      @(negedge clk);
      if (!out_ready) chk("stall_in_ready", int'(in_ready), 0);
      if (in_ready) idx++;
      if (it == rst_at) begin
        #2 rst_n = 0;
        #1;
        chk("rst_outputs", int'({busy, done, ok, in_ready, out_valid}), 0);
        chk("rst_consumed", int'(consumed), 0);
        chk("rst_err_step", int'(err_step), 0);
        in_valid = 0; start = 0; out_ready = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("rst_no_done", int'(done), 0);
        end
        rst_n = 1;
        chk("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        return;
      end
      if (done) begin
        dcyc = it;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_cycle", dcyc, exp_done);
    chk("ok", int'(ok), exp_ok);
    chk("err_step", int'(err_step), exp_err);
    chk("consumed", int'(consumed), exp_cons);
    chk("bytes_taken", idx, exp_cons);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; out_ready = 1; start = 0;
    @(negedge clk);
    chk("idle_after_done", int'({busy, done}), 0);
  endtask

  task automatic prog_csv();
    wr(0, 0, 0, 1, 3);
    wr(1, 6, 8'h2c, 1, 1);
    wr(2, 1, 0, 0, 8);
  endtask

  initial begin
    #12 rst_n = 1;
    @(negedge clk);
    chk("reset_state", int'({busy, done, ok, in_ready, out_valid}), 0);
    chk("reset_consumed", int'(consumed), 0);
    prog_csv();
    push("12", 0); push(",", 1); push("ab", 2);
    run("12,ab;", -1, 3, -1, -1, -1, 12, 1, 0, 5);
    run("x1", -1, 3, -1, -1, -1, 3, 0, 0, 0);
    wr(0, 0, 0, 2, 2);
    push("12", 0);
    run("1234", -1, 1, -1, -1, -1, 5, 1, 0, 2);
    wr(0, 4, 0, 1, 4);
    wr(1, 3, 0, 1, 2);
    push("aF", 0);
    run("aF", 1, 2, -1, -1, -1, 7, 0, 1, 2);
    wr(0, 1, 0, 1, 8);
    push("abcdef", 0);
    run("abcdef!", -1, 1, 4, 7, -1, 13, 1, 0, 6);
    prog_csv();
    push("12", 0);
    run("12,ab;", -1, 3, -1, -1, 3, 0, 0, 0, 0);
    prog_csv();
    push("12", 0); push(",", 1); push("ab", 2);
    run("12,ab;", -1, 3, -1, -1, -1, 12, 1, 0, 5);
    run("123", -1, 0, -1, -1, -1, 1, 1, 0, 0);
    wr(0, 5, 0, 0, 0);
    wr(1, 0, 0, 2, 1);
    run("12", -1, 2, -1, -1, -1, 4, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
